// File: rtl/mem_issue_queue.sv
// mem_issue_queue: in-order load/store issue queue ahead of the memory unit.
// Captures missing operands from the CDB and issues only the head entry, so
// memory traffic leaves in program order. A flush or reset empties the queue.
// An op is treated as a store when its write byte mask is non-zero; loads
// carry a zero write mask and do not wait on rs2.
module mem_issue_queue #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 5,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [31:0]      disp_pc,
    input  logic [31:0]      disp_inst,
    input  logic [31:0]      disp_imm,
    input  logic [2:0]       disp_memop,
    input  logic [3:0]       disp_rmask,
    input  logic [3:0]       disp_wmask,
    input  logic [ROB_W-1:0] disp_rd_rob_idx,
    input  logic             disp_rs1_rdy,
    input  logic             disp_rs2_rdy,
    input  logic [ROB_W-1:0] disp_rs1_tag,
    input  logic [ROB_W-1:0] disp_rs2_tag,
    input  logic [31:0]      disp_rs1_data,
    input  logic [31:0]      disp_rs2_data,

    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_rob_idx,
    input  logic [31:0]      cdb_data,

    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [31:0]      iss_pc,
    output logic [31:0]      iss_inst,
    output logic [31:0]      iss_imm,
    output logic [31:0]      iss_rs1_data,
    output logic [31:0]      iss_rs2_data,
    output logic [2:0]       iss_memop,
    output logic [3:0]       iss_rmask,
    output logic [3:0]       iss_wmask,
    output logic [ROB_W-1:0] iss_rd_rob_idx,

    output logic [CW-1:0]    count
);

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [31:0]      imm;
        logic [2:0]       memop;
        logic [3:0]       rmask;
        logic [3:0]       wmask;
        logic [ROB_W-1:0] rd;
        logic             rs1_rdy;
        logic [ROB_W-1:0] rs1_tag;
        logic [31:0]      rs1_data;
        logic             rs2_rdy;
        logic [ROB_W-1:0] rs2_tag;
        logic [31:0]      rs2_data;
    } entry_t;

    entry_t           ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    entry_t disp_ent;
    logic   full;
    logic   enq;
    logic   deq;
    logic   head_is_store;

    assign full       = (count_q == CW'(DEPTH));
    assign disp_ready = !full;
    assign enq        = disp_valid && disp_ready;

    // Issue outputs come straight from the head entry; no CDB bypass.
    assign head_is_store  = |ent_q[head_q].wmask;
    assign iss_valid      = vld_q[head_q] && ent_q[head_q].rs1_rdy &&
                            (!head_is_store || ent_q[head_q].rs2_rdy);
    assign iss_pc         = ent_q[head_q].pc;
    assign iss_inst       = ent_q[head_q].inst;
    assign iss_imm        = ent_q[head_q].imm;
    assign iss_memop      = ent_q[head_q].memop;
    assign iss_rmask      = ent_q[head_q].rmask;
    assign iss_wmask      = ent_q[head_q].wmask;
    assign iss_rd_rob_idx = ent_q[head_q].rd;
    assign iss_rs1_data   = ent_q[head_q].rs1_data;
    assign iss_rs2_data   = ent_q[head_q].rs2_data;
    assign count          = count_q;

    assign deq = iss_valid && iss_ready;

    // Build the incoming entry, catching an operand broadcast in the dispatch cycle.
    always_comb begin
        disp_ent          = '0;
        disp_ent.pc       = disp_pc;
        disp_ent.inst     = disp_inst;
        disp_ent.imm      = disp_imm;
        disp_ent.memop    = disp_memop;
        disp_ent.rmask    = disp_rmask;
        disp_ent.wmask    = disp_wmask;
        disp_ent.rd       = disp_rd_rob_idx;
        disp_ent.rs1_rdy  = disp_rs1_rdy;
        disp_ent.rs1_tag  = disp_rs1_tag;
        disp_ent.rs1_data = disp_rs1_data;
        disp_ent.rs2_rdy  = disp_rs2_rdy;
        disp_ent.rs2_tag  = disp_rs2_tag;
        disp_ent.rs2_data = disp_rs2_data;
        if (!disp_rs1_rdy && cdb_valid && (disp_rs1_tag == cdb_rob_idx)) begin
            disp_ent.rs1_rdy  = 1'b1;
            disp_ent.rs1_data = cdb_data;
        end
        if (!disp_rs2_rdy && cdb_valid && (disp_rs2_tag == cdb_rob_idx)) begin
            disp_ent.rs2_rdy  = 1'b1;
            disp_ent.rs2_data = cdb_data;
        end
    end

    // Next head/tail/count from the enqueue and dequeue handshakes.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq) begin
            head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + 1'b1;
        end
        if (enq) begin
            tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; flush behaves like reset here.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: resident wakeup, dequeue clear, enqueue write.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && cdb_valid) begin
                    if (!ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == cdb_rob_idx)) begin
                        ent_q[i].rs1_rdy  <= 1'b1;
                        ent_q[i].rs1_data <= cdb_data;
                    end
                    if (!ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == cdb_rob_idx)) begin
                        ent_q[i].rs2_rdy  <= 1'b1;
                        ent_q[i].rs2_data <= cdb_data;
                    end
                end
            end
            if (deq) begin
                vld_q[head_q] <= 1'b0;
            end
            if (enq) begin
                ent_q[tail_q] <= disp_ent;
                vld_q[tail_q] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Bench for mem_issue_queue: a scoreboard of expected issue records is filled
// on accepted dispatches and drained as the queue issues.
module tb_mem_issue_queue;

    localparam int DEPTH = 8;
    localparam int ROB_W = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst, flush;
    logic             disp_valid, disp_ready;
    logic [31:0]      disp_pc, disp_inst, disp_imm;
    logic [2:0]       disp_memop;
    logic [3:0]       disp_rmask, disp_wmask;
    logic [ROB_W-1:0] disp_rd_rob_idx;
    logic             disp_rs1_rdy, disp_rs2_rdy;
    logic [ROB_W-1:0] disp_rs1_tag, disp_rs2_tag;
    logic [31:0]      disp_rs1_data, disp_rs2_data;
    logic             cdb_valid;
    logic [ROB_W-1:0] cdb_rob_idx;
    logic [31:0]      cdb_data;
    logic             iss_valid, iss_ready;
    logic [31:0]      iss_pc, iss_inst, iss_imm, iss_rs1_data, iss_rs2_data;
    logic [2:0]       iss_memop;
    logic [3:0]       iss_rmask, iss_wmask;
    logic [ROB_W-1:0] iss_rd_rob_idx;
    logic [CW-1:0]    count;

    mem_issue_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_pc(disp_pc), .disp_inst(disp_inst), .disp_imm(disp_imm),
        .disp_memop(disp_memop), .disp_rmask(disp_rmask), .disp_wmask(disp_wmask),
        .disp_rd_rob_idx(disp_rd_rob_idx),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_pc(iss_pc), .iss_inst(iss_inst), .iss_imm(iss_imm),
        .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data),
        .iss_memop(iss_memop), .iss_rmask(iss_rmask), .iss_wmask(iss_wmask),
        .iss_rd_rob_idx(iss_rd_rob_idx), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROB_W-1:0] rob;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic             is_store;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_next;
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: compare on issue handshake, record on accepted dispatch.
    always @(negedge clk) begin
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (iss_valid && iss_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_issue", 64'(iss_rd_rob_idx), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("iss_rd_rob_idx", 64'(iss_rd_rob_idx), 64'(e.rob));
                    chk("iss_pc", 64'(iss_pc), 64'(e.pc));
                    chk("iss_imm", 64'(iss_imm), 64'(e.imm));
                    chk("iss_rs1_data", 64'(iss_rs1_data), 64'(e.rs1));
                    if (e.is_store) chk("iss_rs2_data", 64'(iss_rs2_data), 64'(e.rs2));
                end
            end
            if (disp_valid && disp_ready) exp_q.push_back(exp_next);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one dispatch for a cycle; exp_rs1/exp_rs2 are the values the op must issue with.
    task automatic disp(input logic [ROB_W-1:0] rob, input logic [31:0] pc, input logic st,
                        input logic r1_rdy, input logic [ROB_W-1:0] r1_tag, input logic [31:0] r1,
                        input logic r2_rdy, input logic [ROB_W-1:0] r2_tag, input logic [31:0] r2,
                        input logic [31:0] exp_rs1, input logic [31:0] exp_rs2);
        disp_valid      = 1'b1;
        disp_pc         = pc;
        disp_inst       = pc ^ 32'h0000_0023;
        disp_imm        = {27'd0, rob} + 32'd4;
        disp_memop      = 3'b010;
        disp_rmask      = st ? 4'h0 : 4'hF;
        disp_wmask      = st ? 4'hF : 4'h0;
        disp_rd_rob_idx = rob;
        disp_rs1_rdy    = r1_rdy;
        disp_rs1_tag    = r1_tag;
        disp_rs1_data   = r1;
        disp_rs2_rdy    = r2_rdy;
        disp_rs2_tag    = r2_tag;
        disp_rs2_data   = r2;
        exp_next.rob      = rob;
        exp_next.pc       = pc;
        exp_next.imm      = {27'd0, rob} + 32'd4;
        exp_next.rs1      = exp_rs1;
        exp_next.rs2      = exp_rs2;
        exp_next.is_store = st;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic cdb(input logic [ROB_W-1:0] tag, input logic [31:0] data);
        cdb_valid   = 1'b1;
        cdb_rob_idx = tag;
        cdb_data    = data;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        iss_ready = 1'b1;
        while (count != 0 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 64'(count), 64'd0);
        chk({tag, "_sb"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int p0;
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
        disp_pc = '0; disp_inst = '0; disp_imm = '0; disp_memop = '0;
        disp_rmask = '0; disp_wmask = '0; disp_rd_rob_idx = '0;
        disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_rs1_tag = '0; disp_rs2_tag = '0;
        disp_rs1_data = '0; disp_rs2_data = '0;
        cdb_valid = 1'b0; cdb_rob_idx = '0; cdb_data = '0;
        exp_next = '{default: '0};
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_disp_ready", 64'(disp_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_iss_pc", 64'(iss_pc), 64'd0);
        chk("rst_iss_rs1", 64'(iss_rs1_data), 64'd0);

        // Ready load issues the cycle after dispatch; its unready rs2 is ignored.
        disp(5'd1, 32'h100, 1'b0, 1'b1, 5'd0, 32'h1000, 1'b0, 5'd31, 32'h0, 32'h1000, 32'h0);
        chk("ld_iss_valid", 64'(iss_valid), 64'd1);
        chk("ld_rs1", 64'(iss_rs1_data), 64'h1000);
        chk("ld_imm", 64'(iss_imm), 64'd5);
        chk("ld_count", 64'(count), 64'd1);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        chk("ld_count_after", 64'(count), 64'd0);
        chk("ld_iss_valid_after", 64'(iss_valid), 64'd0);

        // Store waits on rs2 tag 7 until the CDB broadcast three cycles later.
        disp(5'd2, 32'h104, 1'b1, 1'b1, 5'd0, 32'h2000, 1'b0, 5'd7, 32'h0, 32'h2000, 32'hDEADBEEF);
        chk("st_wait1", 64'(iss_valid), 64'd0);
        tick();
        chk("st_wait2", 64'(iss_valid), 64'd0);
        tick();
        chk("st_wait3", 64'(iss_valid), 64'd0);
        cdb(5'd7, 32'hDEADBEEF);
        tick();
        cdb_valid = 1'b0;
        chk("st_wake_valid", 64'(iss_valid), 64'd1);
        chk("st_wake_rs2", 64'(iss_rs2_data), 64'hDEADBEEF);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;

        // Operand broadcast in the dispatch cycle itself is captured.
        cdb(5'd9, 32'hCAFE0009);
        disp(5'd6, 32'h108, 1'b1, 1'b0, 5'd9, 32'h0, 1'b0, 5'd9, 32'h0, 32'hCAFE0009, 32'hCAFE0009);
        cdb_valid = 1'b0;
        chk("disp_wake_valid", 64'(iss_valid), 64'd1);
        drain("disp_wake_drain");

        // Blocked older store holds back a ready younger load.
        iss_ready = 1'b1;
        disp(5'd3, 32'h200, 1'b1, 1'b1, 5'd0, 32'h3000, 1'b0, 5'd12, 32'h0, 32'h3000, 32'h12121212);
        disp(5'd4, 32'h204, 1'b0, 1'b1, 5'd0, 32'h4000, 1'b0, 5'd0, 32'h0, 32'h4000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("order_blocked", 64'(iss_valid), 64'd0);
            chk("order_head", 64'(iss_rd_rob_idx), 64'd3);
            tick();
        end
        p0 = pops;
        cdb(5'd12, 32'h12121212);
        tick();
        cdb_valid = 1'b0;
        drain("order_drain");
        chk("order_pops", 64'(pops - p0), 64'd2);

        // Fill to capacity; a same-cycle dequeue does not free a dispatch slot.
        iss_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            disp(5'(8 + i), 32'h300 + 32'(i * 4), 1'b0, 1'b1, 5'd0, 32'h5000 + 32'(i), 1'b0, 5'd0, 32'h0,
                 32'h5000 + 32'(i), 32'h0);
        chk("full_count", 64'(count), 64'd8);
        chk("full_disp_ready", 64'(disp_ready), 64'd0);
        iss_ready = 1'b1;
        disp(5'd30, 32'h3FC, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        chk("full_deq_count", 64'(count), 64'd7);
        chk("full_deq_ready", 64'(disp_ready), 64'd1);
        drain("full_drain");

        // Back-to-back stream wraps the pointers at one issue per cycle.
        p0 = pops;
        iss_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            disp(5'(i), 32'h400 + 32'(i * 4), 1'b0, 1'b1, 5'd0, 32'h6000 + 32'(i), 1'b0, 5'd0, 32'h0,
                 32'h6000 + 32'(i), 32'h0);
            chk("stream_count", 64'(count), 64'd1);
        end
        drain("stream_drain");
        chk("stream_pops", 64'(pops - p0), 64'd20);

        // Stalled head stays stable; an already-ready operand ignores a matching broadcast.
        iss_ready = 1'b0;
        disp(5'd20, 32'h500, 1'b1, 1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 32'h11, 32'h22);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) cdb(5'd5, 32'hBAD);
            chk("stall_valid", 64'(iss_valid), 64'd1);
            chk("stall_pc", 64'(iss_pc), 64'h500);
            chk("stall_rs1", 64'(iss_rs1_data), 64'h11);
            chk("stall_rs2", 64'(iss_rs2_data), 64'h22);
            chk("stall_rob", 64'(iss_rd_rob_idx), 64'd20);
            tick();
            cdb_valid = 1'b0;
        end
        drain("stall_drain");

        // Flush with five entries and a concurrent dispatch drops everything.
        iss_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            disp(5'(i + 1), 32'h600 + 32'(i * 4), 1'b0, 1'b1, 5'd0, 32'h7000, 1'b0, 5'd0, 32'h0, 32'h7000, 32'h0);
        chk("pre_flush_count", 64'(count), 64'd5);
        flush = 1'b1;
        disp(5'd25, 32'h6FC, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        flush = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_iss_valid", 64'(iss_valid), 64'd0);
        chk("flush_disp_ready", 64'(disp_ready), 64'd1);
        disp(5'd26, 32'h700, 1'b0, 1'b1, 5'd0, 32'h8000, 1'b0, 5'd0, 32'h0, 32'h8000, 32'h0);
        chk("post_flush_count", 64'(count), 64'd1);
        chk("post_flush_rob", 64'(iss_rd_rob_idx), 64'd26);
        drain("post_flush_drain");

        // Reset mid-operation discards entries and zeroes storage.
        iss_ready = 1'b0;
        disp(5'd27, 32'h800, 1'b0, 1'b1, 5'd0, 32'h9000, 1'b0, 5'd0, 32'h0, 32'h9000, 32'h0);
        disp(5'd28, 32'h804, 1'b0, 1'b1, 5'd0, 32'h9001, 1'b0, 5'd0, 32'h0, 32'h9001, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(iss_valid), 64'd0);
        chk("mid_rst_pc", 64'(iss_pc), 64'd0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_issue_queue.md
# mem_issue_queue

In-order load/store issue queue sitting directly upstream of the memory unit. Accepts memory ops from dispatch, captures missing rs1/rs2 operands by snooping the CDB, and presents the oldest op to the memory unit once its operands are ready. Issue is strictly in program order (head only), so the memory unit and store buffer never see reordered memory traffic. A CDB flush empties the queue.

## Interface
- DEPTH, 8, number of entries (>= 2, any integer)
- ROB_W, 5, ROB index / operand tag width
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  CDB flush; drops all entries
- disp_valid  in  1  dispatch offers a memory op
- disp_ready  out  1  queue can accept (= !full)
- disp_pc, disp_inst, disp_imm  in  32 each  op PC, instruction word, sign-extended immediate
- disp_memop  in  3  mem_op encoding (b/bu/h/hu/w)
- disp_rmask, disp_wmask  in  4 each  unshifted byte masks
- disp_rd_rob_idx  in  ROB_W  destination ROB index
- disp_rs1_rdy, disp_rs2_rdy  in  1 each  operand already available
- disp_rs1_tag, disp_rs2_tag  in  ROB_W each  producer ROB index when not ready
- disp_rs1_data, disp_rs2_data  in  32 each  operand value when ready
- cdb_valid  in  1  CDB broadcast valid
- cdb_rob_idx  in  ROB_W  broadcast tag
- cdb_data  in  32  broadcast value
- iss_valid  out  1  head op ready to issue
- iss_ready  in  1  memory unit accepts (driven as !mem_stall)
- iss_pc, iss_inst, iss_imm, iss_rs1_data, iss_rs2_data  out  32 each  head op fields
- iss_memop  out  3; iss_rmask, iss_wmask  out  4; iss_rd_rob_idx  out  ROB_W
- count  out  $clog2(DEPTH+1)  occupancy

## Operation
- Storage: DEPTH entries {valid, fields, rs1_rdy, rs1_tag, rs1_data, rs2_rdy, rs2_tag, rs2_data}; head/tail pointers wrap DEPTH-1 -> 0; count register.
- Enqueue when disp_valid && disp_ready: write at tail, tail++, count++.
- Dispatch-cycle wakeup: if cdb_valid and an incoming not-ready operand's tag equals cdb_rob_idx, store it as ready with cdb_data.
- Resident wakeup: every valid entry with rsX_rdy=0 and rsX_tag==cdb_rob_idx under cdb_valid sets rsX_rdy=1, rsX_data=cdb_data (both operands may wake together).
- rs2 readiness is required for stores only; loads issue on rs1 alone (rs2_rdy ignored).
- iss_valid = head valid && rs1_rdy && (load || rs2_rdy); iss_* fields are head entry contents (no CDB bypass to issue outputs).
- Dequeue when iss_valid && iss_ready: clear head valid, head++, count--.
- Simultaneous enqueue+dequeue: count unchanged, both pointers advance.
- Full: disp_ready=0 even if a dequeue happens the same cycle (no pass-through).
- Empty: iss_valid=0; entering entry issues no earlier than next cycle.
- flush: all valid bits, head, tail, count cleared next edge; dispatch and dequeue that cycle ignored. flush takes priority over everything except rst.
- rst: same as flush; rst mid-operation discards all entries.

## Timing
- Reset values: iss_valid=0, disp_ready=1, count=0, all iss_* data fields 0 (entry storage zeroed).
- Dispatch with operands ready at cycle N -> iss_valid=1 at N+1 (if at head).
- CDB wakeup at cycle N -> entry ready at N+1.
- iss_* outputs combinational from registered state only; no input-to-output combinational path except none: iss_valid does not depend on iss_ready.
- iss_* held stable while iss_valid && !iss_ready.
- Throughput: one issue per cycle when iss_ready stays high.

## Test plan
- Reset, then dispatch load (rs1_rdy=1, rs1_data=0x1000, imm=4) at N -> iss_valid=1 at N+1 with iss_rs1_data=0x1000; iss_ready=1 -> count returns to 0.
- Dispatch store with rs2 tag 7 not ready; cdb_valid, rob_idx=7, data=0xDEADBEEF at N+3 -> iss_valid rises N+4, iss_rs2_data=0xDEADBEEF.
- Older store blocked on rs2, younger ready load behind it -> load never issues before store; order of iss_rd_rob_idx matches dispatch order.
- Fill 8 entries with iss_ready=0 -> disp_ready=0, count=8; one dequeue with disp_valid=1 same cycle -> dispatch not accepted, count=7; pointer wrap verified over 20 ops.
- iss_ready=0 for 5 cycles with head ready -> all iss_* stable.
- flush with 5 entries and concurrent dispatch -> next cycle count=0, iss_valid=0, dispatched op dropped.
